// File: rtl/data_mem_arb_pkg.sv
// Shared definitions for the data memory arbiter: FSM state codes, grant owner codes
// and the counter sizing helper.
package data_mem_arb_pkg;
    localparam logic [0:0] S_CPU = 1'b0;
    localparam logic [0:0] S_DMA = 1'b1;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_DMA  = 2'd2;

    // Bits needed to hold a count of 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/data_mem_resp_reg.sv
// Read response register for one requester: captures memory read data at the end of a
// granted read and raises rvalid for exactly the following cycle.
module data_mem_resp_reg
    import data_mem_arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cap_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o
);
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= cap_i;
            if (cap_i) begin
                rdata_q <= data_i;
            end
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
endmodule

// File: rtl/data_mem_arbiter.sv
// Single-port data memory arbiter between the CPU MEM stage and a loader/DMA engine:
// CPU priority by default, starvation-forced DMA entry, and bounded DMA bursts.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_BURST    = 8
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_stall,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_rvalid,
    input  logic              i_dma_req,
    input  logic              i_dma_we,
    input  logic [ADDR_W-1:0] i_dma_addr,
    input  logic [DATA_W-1:0] i_dma_wdata,
    input  logic              i_dma_last,
    output logic              o_dma_gnt,
    output logic [DATA_W-1:0] o_dma_rdata,
    output logic              o_dma_rvalid,
    output logic              o_MemWrite,
    output logic              o_MemRead,
    output logic [ADDR_W-1:0] o_Address,
    output logic [DATA_W-1:0] o_Write_Data,
    input  logic [DATA_W-1:0] i_Read_Data
);
    localparam int SW = cnt_w(STARVE_LIMIT);
    localparam int BW = cnt_w(MAX_BURST);
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 1);
    localparam logic [BW-1:0] BEAT_LAST   = BW'(MAX_BURST - 1);

    logic [0:0]    state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          cpu_gnt, dma_gnt;
    logic [1:0]    owner;

    // No access is granted while reset is held, so the memory sees no strobe mid-reset.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!i_RST) begin
            if (state_q == S_DMA) begin
                dma_gnt = i_dma_req;
                cpu_gnt = i_cpu_req & ~i_dma_req;
            end else begin
                cpu_gnt = i_cpu_req;
                dma_gnt = i_dma_req & ~i_cpu_req;
            end
        end
    end

    assign owner       = cpu_gnt ? OWN_CPU : (dma_gnt ? OWN_DMA : OWN_NONE);
    assign o_cpu_stall = i_cpu_req & ~cpu_gnt;
    assign o_dma_gnt   = dma_gnt;

    always_comb begin
        o_MemWrite   = 1'b0;
        o_MemRead    = 1'b0;
        o_Address    = '0;
        o_Write_Data = '0;
        case (owner)
            OWN_CPU: begin
                o_MemWrite   = i_cpu_we;
                o_MemRead    = ~i_cpu_we;
                o_Address    = i_cpu_addr;
                o_Write_Data = i_cpu_wdata;
            end
            OWN_DMA: begin
                o_MemWrite   = i_dma_we;
                o_MemRead    = ~i_dma_we;
                o_Address    = i_dma_addr;
                o_Write_Data = i_dma_wdata;
            end
            default: ;
        endcase
    end

    // A DMA beat always clears starvation; in S_DMA an idle DMA slot leaves all state alone.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        beat_d   = beat_q;
        if (dma_gnt) begin
            starve_d = '0;
            if (i_dma_last || (beat_q == BEAT_LAST)) begin
                state_d = S_CPU;
                beat_d  = '0;
            end else begin
                state_d = S_DMA;
                beat_d  = beat_q + BW'(1);
            end
        end else if (state_q == S_CPU) begin
            if (cpu_gnt && i_dma_req) begin
                if (starve_q == STARVE_LAST) begin
                    state_d  = S_DMA;
                    starve_d = '0;
                end else begin
                    starve_d = starve_q + SW'(1);
                end
            end else begin
                starve_d = '0;
            end
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q  <= S_CPU;
            starve_q <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            beat_q   <= beat_d;
        end
    end

    data_mem_resp_reg #(.DATA_W(DATA_W)) u_cpu_resp (
        .clk_i   (i_CLK),
        .rst_i   (i_RST),
        .cap_i   (cpu_gnt & ~i_cpu_we),
        .data_i  (i_Read_Data),
        .rdata_o (o_cpu_rdata),
        .rvalid_o(o_cpu_rvalid)
    );

    data_mem_resp_reg #(.DATA_W(DATA_W)) u_dma_resp (
        .clk_i   (i_CLK),
        .rst_i   (i_RST),
        .cap_i   (dma_gnt & ~i_dma_we),
        .data_i  (i_Read_Data),
        .rdata_o (o_dma_rdata),
        .rvalid_o(o_dma_rvalid)
    );
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus randomized requester traffic,
// checked against a transaction-level ownership model and a reference memory image.
module tb_data_mem_arbiter;
    localparam int ADDR_W       = 10;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 4;
    localparam int MAX_BURST    = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_stall, cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              dma_req = 1'b0, dma_we = 1'b0, dma_last = 1'b0;
    logic [ADDR_W-1:0] dma_addr = '0;
    logic [DATA_W-1:0] dma_wdata = '0;
    logic              dma_gnt, dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;
    logic              mem_we, mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wd, read_data;

    logic [DATA_W-1:0] mem     [1024];
    logic [DATA_W-1:0] ref_mem [1024];

    int checks = 0;
    int failures = 0;

    // Reference model: who owns the memory, CPU wins in a row under contention, DMA beats this ownership.
    bit m_dma_owns;
    int m_cpu_wins, m_beats;
    bit exp_cg, exp_dg, exp_crv, exp_drv;
    logic [DATA_W-1:0] exp_crd, exp_drd;

    always #5 clk = ~clk;
    assign read_data = mem[mem_addr];

    data_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT), .MAX_BURST(MAX_BURST)
    ) dut (
        .i_CLK(clk), .i_RST(rst),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_stall(cpu_stall), .o_cpu_rdata(cpu_rdata), .o_cpu_rvalid(cpu_rvalid),
        .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_addr(dma_addr), .i_dma_wdata(dma_wdata),
        .i_dma_last(dma_last), .o_dma_gnt(dma_gnt), .o_dma_rdata(dma_rdata), .o_dma_rvalid(dma_rvalid),
        .o_MemWrite(mem_we), .o_MemRead(mem_re), .o_Address(mem_addr), .o_Write_Data(mem_wd),
        .i_Read_Data(read_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_dma_owns = 1'b0;
        m_cpu_wins = 0;
        m_beats    = 0;
        exp_crv    = 1'b0;
        exp_drv    = 1'b0;
        exp_crd    = '0;
        exp_drd    = '0;
    endtask

    // One clock cycle: inputs already driven just after a negedge.
    task automatic step();
        logic              e_mw, e_mr, cap_we;
        logic [ADDR_W-1:0] e_addr, cap_a;
        logic [DATA_W-1:0] e_wd, cap_d;
        #1;
        if (m_dma_owns) begin
            exp_dg = dma_req;
            exp_cg = cpu_req && !dma_req;
        end else begin
            exp_cg = cpu_req;
            exp_dg = dma_req && !cpu_req;
        end
        e_mw = 1'b0; e_mr = 1'b0; e_addr = '0; e_wd = '0;
        if (exp_cg) begin
            e_mw = cpu_we; e_mr = !cpu_we; e_addr = cpu_addr; e_wd = cpu_wdata;
        end else if (exp_dg) begin
            e_mw = dma_we; e_mr = !dma_we; e_addr = dma_addr; e_wd = dma_wdata;
        end
        chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !exp_cg));
        chk("dma_gnt", 32'(dma_gnt), 32'(exp_dg));
        chk("MemWrite", 32'(mem_we), 32'(e_mw));
        chk("MemRead", 32'(mem_re), 32'(e_mr));
        chk("Address", 32'(mem_addr), 32'(e_addr));
        if (!e_mr) chk("Write_Data", mem_wd, e_wd);
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_crv));
        chk("cpu_rdata", cpu_rdata, exp_crd);
        chk("dma_rvalid", 32'(dma_rvalid), 32'(exp_drv));
        chk("dma_rdata", dma_rdata, exp_drd);
        cap_we = mem_we; cap_a = mem_addr; cap_d = mem_wd;
        @(posedge clk);
        if (cap_we) mem[cap_a] = cap_d;
        exp_crv = exp_cg && !cpu_we;
        exp_drv = exp_dg && !dma_we;
        if (exp_crv) exp_crd = ref_mem[cpu_addr];
        if (exp_drv) exp_drd = ref_mem[dma_addr];
        if (exp_cg && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
        if (exp_dg && dma_we) ref_mem[dma_addr] = dma_wdata;
        if (exp_dg) begin
            m_cpu_wins = 0;
            m_beats++;
            if (dma_last || m_beats == MAX_BURST) begin
                m_dma_owns = 1'b0;
                m_beats    = 0;
            end else begin
                m_dma_owns = 1'b1;
            end
        end else if (!m_dma_owns) begin
            if (exp_cg && dma_req) begin
                m_cpu_wins++;
                if (m_cpu_wins == STARVE_LIMIT) begin
                    m_dma_owns = 1'b1;
                    m_cpu_wins = 0;
                end
            end else begin
                m_cpu_wins = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        cpu_req  = 1'b0;
        dma_req  = 1'b0;
        dma_last = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int beat, bad;
        bit cp, dp, cpu_done;
        logic [DATA_W-1:0] bw [13];

        for (int i = 0; i < 1024; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[5]     = 32'hDEADBEEF;
        ref_mem[5] = 32'hDEADBEEF;

        // Reset state
        #2 rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_dma_rdata", dma_rdata, 32'd0);
        chk("rst_memwrite", 32'(mem_we), 32'd0);
        chk("rst_memread", 32'(mem_re), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // CPU-only read of a preloaded word
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd5;
        #1 chk("t1_memread", 32'(mem_re), 32'd1);
        step();
        chk("t1_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("t1_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        idle(); step();

        // CPU write and DMA read of the same address
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'd7; cpu_wdata = 32'h12345678;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 10'd7; dma_last = 1'b1;
        #1 chk("t2_dma_wait", 32'(dma_gnt), 32'd0);
        step();
        cpu_req = 1'b0;
        #1 chk("t2_dma_gnt", 32'(dma_gnt), 32'd1);
        step();
        chk("t2_dma_rvalid", 32'(dma_rvalid), 32'd1);
        chk("t2_dma_rdata", dma_rdata, 32'h12345678);
        idle(); step();

        // Starvation forces one DMA beat after STARVE_LIMIT CPU wins
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd1;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 10'd2; dma_last = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("t3_dma_gnt", 32'(dma_gnt), 32'(c == 4));
            chk("t3_cpu_stall", 32'(cpu_stall), 32'(c == 4));
            step();
        end
        idle(); step();

        // Burst cap: 12 write beats, CPU waits from beat 3 and gets in after beat 8
        for (int k = 1; k <= 12; k++) bw[k] = $urandom;
        beat = 1; cpu_done = 1'b0;
        cpu_we = 1'b0; cpu_addr = 10'd3;
        for (int c = 0; c < 13; c++) begin
            dma_req = 1'b1; dma_we = 1'b1; dma_addr = 10'(100 + beat);
            dma_wdata = bw[beat]; dma_last = (beat == 12);
            cpu_req = (beat >= 3) && !cpu_done;
            #1 chk("t4_dma_gnt", 32'(dma_gnt), 32'(c != 8));
            step();
            if (exp_dg) beat++;
            if (exp_cg) cpu_done = 1'b1;
        end
        chk("t4_beats_done", 32'(beat), 32'd13);
        idle(); step();
        for (int k = 1; k <= 12; k++) chk("t4_mem", mem[100 + k], bw[k]);

        // Idle DMA slot lent to the CPU must not count as a burst beat
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 10'd40; dma_wdata = 32'hA5A50001; dma_last = 1'b0;
        step();
        dma_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'd41; cpu_wdata = 32'h0BADF00D;
        #1;
        chk("t5_lent_stall", 32'(cpu_stall), 32'd0);
        chk("t5_lent_write", 32'(mem_we), 32'd1);
        step();
        cpu_we = 1'b0;
        beat = 2;
        for (int c = 2; c <= 10; c++) begin
            dma_req = 1'b1; dma_addr = 10'(40 + beat); dma_wdata = 32'(beat); dma_last = (beat == 9);
            cpu_req = (c <= 9);
            #1;
            chk("t5_dma_gnt", 32'(dma_gnt), 32'(c != 9));
            chk("t5_cpu_stall", 32'(cpu_stall), 32'(c <= 8));
            step();
            if (exp_dg) beat++;
            if (c == 9) chk("t5_cpu_rdata", cpu_rdata, 32'h0BADF00D);
        end
        idle(); step();

        // Asynchronous reset in the middle of a burst
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 10'd200; dma_wdata = 32'hC0FFEE01; dma_last = 1'b0;
        step();
        dma_we = 1'b0;
        step();
        dma_we = 1'b1; dma_addr = 10'd201; dma_wdata = 32'hC0FFEE03;
        #1 chk("t6_pre_rvalid", 32'(dma_rvalid), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("t6_memwrite", 32'(mem_we), 32'd0);
        chk("t6_memread", 32'(mem_re), 32'd0);
        chk("t6_dma_gnt", 32'(dma_gnt), 32'd0);
        chk("t6_dma_rvalid", 32'(dma_rvalid), 32'd0);
        chk("t6_dma_rdata", dma_rdata, 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd200;
        dma_addr = 10'd200; dma_wdata = 32'hC0FFEE01; dma_last = 1'b0;
        #1;
        chk("t6_cpu_first", 32'(cpu_stall), 32'd0);
        chk("t6_dma_held", 32'(dma_gnt), 32'd0);
        step();
        chk("t6_cpu_rdata", cpu_rdata, 32'hC0FFEE01);
        cpu_req = 1'b0;
        step();
        dma_addr = 10'd201; dma_wdata = 32'hC0FFEE03; dma_last = 1'b1;
        step();
        idle(); step();

        // Randomized requesters that hold each request until it is granted
        cp = 1'b0; dp = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!cp && $urandom_range(0, 99) < 45) begin
                cp = 1'b1;
                cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = 10'($urandom_range(0, 63));
                cpu_wdata = $urandom;
            end
            if (!dp && $urandom_range(0, 99) < 60) begin
                dp = 1'b1;
                dma_we = 1'($urandom_range(0, 1));
                dma_addr = 10'($urandom_range(0, 63));
                dma_wdata = $urandom;
                dma_last = ($urandom_range(0, 4) == 0);
            end
            cpu_req = cp;
            dma_req = dp;
            step();
            if (exp_cg) cp = 1'b0;
            if (exp_dg) dp = 1'b0;
        end
        idle(); step();

        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("final_mem_words_wrong", 32'(bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
